// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences the UART transceiver for the scope command path.
// RX: assembles 3-byte commands {opcode, data_hi, data_lo} from the receiver
//     byte stream and discards a stale partial frame after TO_CYCLES idle clocks.
// TX: serializes a 1- or 2-byte response into the transmitter.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rdy, rx_data, clr_rdy    receiver handshake (clr_rdy pulses after accept)
//   trmt, tx_data, tx_done   transmitter handshake
//   cmd, cmd_rdy, clr_cmd_rdy  assembled command to the dispatcher
//   frame_err                pulse when a partial frame is discarded
//   resp_req, resp_data, resp_two, resp_busy, resp_sent  response interface
module uart_cmd_ctrl #(
    parameter int unsigned TO_CYCLES = 1000000,
    parameter int unsigned TO_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frame_err,
    input  logic        resp_req,
    input  logic [15:0] resp_data,
    input  logic        resp_two,
    output logic        resp_busy,
    output logic        resp_sent
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 24;
    localparam int unsigned CNT_W  = 2;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOAD         = 3'd1,
        WAIT_LO_EDGE = 3'd2,
        WAIT_HI_DONE = 3'd3,
        DONE         = 3'd4
    } tx_state_e;

    // RX registers
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic [BYTE_W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              clr_rdy_q, clr_rdy_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_accept;

    // TX registers
    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              two_q, two_d;
    logic              trmt_q, trmt_d;
    logic              busy_q, busy_d;
    logic              sent_q, sent_d;
    logic              done_prev_q;
    logic              done_rise;

    // clr_rdy_q masks the cycle before the receiver drops rdy
    assign rx_accept = rdy && !clr_rdy_q && !cmd_rdy_q;
    assign done_rise = tx_done && !done_prev_q;

    // RX byte assembly and partial-frame timeout
    always_comb begin
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        clr_rdy_d   = rx_accept;
        frame_err_d = 1'b0;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (rx_accept) begin
            timer_d = '0;
            case (cnt_q)
                2'd0: begin
                    b0_d  = rx_data;
                    cnt_d = 2'd1;
                end
                2'd1: begin
                    b1_d  = rx_data;
                    cnt_d = 2'd2;
                end
                default: begin
                    cmd_d     = {b0_q, b1_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    cnt_d     = '0;
                end
            endcase
        end else if (cnt_q != '0) begin
            if (timer_q == TO_LAST) begin
                cnt_d       = '0;
                timer_d     = '0;
                frame_err_d = 1'b1;
            end else begin
                timer_d = timer_q + TO_W'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // TX next-state and outputs
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        lo_d      = lo_q;
        two_d     = two_q;
        trmt_d    = 1'b0;
        busy_d    = busy_q;
        sent_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (resp_req) begin
                    lo_d      = resp_data[7:0];
                    two_d     = resp_two;
                    busy_d    = 1'b1;
                    tx_data_d = resp_two ? resp_data[15:8] : resp_data[7:0];
                    trmt_d    = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_LO_EDGE;
            end
            WAIT_LO_EDGE: begin
                if (done_rise) begin
                    if (two_q) begin
                        tx_data_d = lo_q;
                        two_d     = 1'b0;
                        trmt_d    = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        sent_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            timer_q     <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            clr_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= IDLE;
            tx_data_q   <= '0;
            lo_q        <= '0;
            two_q       <= 1'b0;
            trmt_q      <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            clr_rdy_q   <= clr_rdy_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            lo_q        <= lo_d;
            two_q       <= two_d;
            trmt_q      <= trmt_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            done_prev_q <= tx_done;
        end
    end

    assign clr_rdy   = clr_rdy_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_busy = busy_q;
    assign resp_sent = sent_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: behavioural model + per-cycle compare, directed tests.
module tb_uart_cmd_ctrl;

    localparam int unsigned TO = 16;

    logic        clk, rst_n;
    logic        rdy, clr_rdy, trmt, tx_done, cmd_rdy, clr_cmd_rdy, frame_err;
    logic        resp_req, resp_two, resp_busy, resp_sent;
    logic [7:0]  rx_data, tx_data;
    logic [23:0] cmd;
    logic [15:0] resp_data;

    uart_cmd_ctrl #(.TO_CYCLES(TO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
        .resp_req(resp_req), .resp_data(resp_data), .resp_two(resp_two),
        .resp_busy(resp_busy), .resp_sent(resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic        m_clr, m_cmd_rdy, m_ferr, m_trmt, m_busy, m_sent, m_prev;
    logic [23:0] m_cmd;
    logic [7:0]  m_txd;
    logic [7:0]  frame[$];
    logic [7:0]  pending[$];
    int          cyc, last_acc;

    initial begin
        logic acc, idle, waiting, rise;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_clr = 0; m_cmd_rdy = 0; m_ferr = 0; m_trmt = 0; m_busy = 0;
                m_sent = 0; m_prev = 0; m_cmd = '0; m_txd = '0;
                frame.delete(); pending.delete(); cyc = 0; last_acc = 0;
            end else begin
                cyc++;
                // receive: a byte is taken only when the previous one was not just cleared
                acc    = rdy && !m_clr && !m_cmd_rdy;
                m_ferr = 0;
                if (clr_cmd_rdy) m_cmd_rdy = 0;
                if (acc) begin
                    frame.push_back(rx_data);
                    last_acc = cyc;
                    if (frame.size() == 3) begin
                        m_cmd     = {frame[0], frame[1], frame[2]};
                        m_cmd_rdy = 1;
                        frame.delete();
                    end
                end else if (frame.size() != 0 && (cyc - last_acc) == int'(TO)) begin
                    frame.delete();
                    m_ferr = 1;
                end
                m_clr = acc;
                // transmit
                rise    = tx_done && !m_prev;
                m_prev  = tx_done;
                idle    = !m_busy && !m_sent;
                waiting = m_busy && !m_trmt;
                m_trmt  = 0;
                m_sent  = 0;
                if (idle && resp_req) begin
                    pending.delete();
                    if (resp_two) begin
                        m_txd = resp_data[15:8];
                        pending.push_back(resp_data[7:0]);
                    end else begin
                        m_txd = resp_data[7:0];
                    end
                    m_busy = 1;
                    m_trmt = 1;
                end else if (waiting && rise) begin
                    if (pending.size() != 0) begin
                        m_txd  = pending.pop_front();
                        m_trmt = 1;
                    end else begin
                        m_busy = 0;
                        m_sent = 1;
                    end
                end
            end
        end
    end

    // ---------------- compare + event log ----------------
    logic [7:0] trmt_log[$];
    int sent_cnt = 0, clr_cnt = 0, ferr_cnt = 0, cmdrdy_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("clr_rdy",   32'(clr_rdy),   32'(m_clr));
                check("cmd",       32'(cmd),       32'(m_cmd));
                check("cmd_rdy",   32'(cmd_rdy),   32'(m_cmd_rdy));
                check("frame_err", 32'(frame_err), 32'(m_ferr));
                check("trmt",      32'(trmt),      32'(m_trmt));
                check("tx_data",   32'(tx_data),   32'(m_txd));
                check("resp_busy", 32'(resp_busy), 32'(m_busy));
                check("resp_sent", 32'(resp_sent), 32'(m_sent));
                if (trmt)      trmt_log.push_back(tx_data);
                if (resp_sent) sent_cnt++;
                if (clr_rdy)   clr_cnt++;
                if (frame_err) ferr_cnt++;
                if (cmd_rdy)   cmdrdy_cnt++;
            end
        end
    end

    // ---------------- transmitter model ----------------
    int tcnt;
    initial begin
        tx_done = 1'b1;
        tcnt    = 0;
        forever begin
            @(posedge clk); #1;
            if (trmt) begin
                tx_done = 1'b0;
                tcnt    = 20;
            end else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) tx_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 0;
        rdy = 1; rx_data = b;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (clr_rdy) begin
                got = 1;
                step();   // keep rdy high through the clr_rdy cycle
                rdy = 0;
            end
        end
        check("rx handshake", 32'(got), 32'd1);
    endtask

    task automatic send_resp(input logic [15:0] d, input logic two);
        resp_req = 1; resp_data = d; resp_two = two;
        step();
        resp_req = 0;
    endtask

    task automatic wait_sent(input int target);
        for (int i = 0; i < 300 && sent_cnt < target; i++) step();
        check("resp_sent wait", 32'(sent_cnt >= target), 32'd1);
    endtask

    initial begin
        int base_log, base_sent, base_cr;
        rst_n = 0; rdy = 0; rx_data = '0; clr_cmd_rdy = 0;
        resp_req = 0; resp_data = '0; resp_two = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset clr_rdy", 32'(clr_rdy), 32'd0);
        check("reset cmd", 32'(cmd), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset outputs", 32'({trmt, cmd_rdy, frame_err, resp_busy, resp_sent}), 32'd0);
        @(negedge clk); rst_n = 1;
        step();

        // three-byte command
        send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
        check("cmd 051234", 32'(cmd), 32'h051234);
        check("cmd_rdy set", 32'(cmd_rdy), 32'd1);
        check("clr_rdy pulses", 32'(clr_cnt), 32'd3);
        check("no frame_err", 32'(ferr_cnt), 32'd0);

        // backpressure while cmd_rdy is held
        rdy = 1; rx_data = 8'hAA;
        repeat (6) step();
        check("backpressure clr_rdy", 32'(clr_cnt), 32'd3);
        clr_cmd_rdy = 1;
        step();
        clr_cmd_rdy = 0;
        check("cmd_rdy cleared", 32'(cmd_rdy), 32'd0);
        check("no accept yet", 32'(clr_rdy), 32'd0);
        step();
        check("AA accepted", 32'(clr_rdy), 32'd1);
        step();
        rdy = 0;
        check("cmd unchanged", 32'(cmd), 32'h051234);

        // the lone 0xAA goes stale
        for (int i = 0; i < 40 && ferr_cnt == 0; i++) step();
        check("frame_err pulse", 32'(ferr_cnt), 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check("cmd 010203", 32'(cmd), 32'h010203);
        clr_cmd_rdy = 1; step(); clr_cmd_rdy = 0;

        // two-byte response
        base_log = trmt_log.size();
        send_resp(16'hBEEF, 1'b1);
        check("busy after req", 32'(resp_busy), 32'd1);
        wait_sent(1);
        step();
        check("two bytes sent", 32'(trmt_log.size() - base_log), 32'd2);
        if (trmt_log.size() >= base_log + 2) begin
            check("first byte BE", 32'(trmt_log[base_log]), 32'hBE);
            check("second byte EF", 32'(trmt_log[base_log+1]), 32'hEF);
        end
        check("busy low after", 32'(resp_busy), 32'd0);

        // one-byte response with an ignored second request
        base_log = trmt_log.size(); base_sent = sent_cnt;
        send_resp(16'h1234, 1'b0);
        repeat (5) step();
        send_resp(16'hFFFF, 1'b1);
        wait_sent(base_sent + 1);
        repeat (60) step();
        check("one byte sent", 32'(trmt_log.size() - base_log), 32'd1);
        if (trmt_log.size() > base_log)
            check("byte 34", 32'(trmt_log[base_log]), 32'h34);
        check("one resp_sent", 32'(sent_cnt - base_sent), 32'd1);

        // reset mid-transmit and mid-frame
        send_byte(8'h77);
        base_log = trmt_log.size();
        send_resp(16'hA55A, 1'b1);
        for (int i = 0; i < 200 && trmt_log.size() < base_log + 2; i++) step();
        check("second trmt reached", 32'(trmt_log.size() - base_log), 32'd2);
        repeat (3) step();
        rst_n = 0;
        #1;
        check("abort busy", 32'(resp_busy), 32'd0);
        check("abort cmd", 32'(cmd), 32'd0);
        check("abort outputs", 32'({clr_rdy, trmt, cmd_rdy, frame_err, resp_sent}), 32'd0);
        check("abort tx_data", 32'(tx_data), 32'd0);
        repeat (3) step();
        @(negedge clk); rst_n = 1;
        base_sent = sent_cnt; base_cr = cmdrdy_cnt;
        repeat (60) step();
        check("no resp_sent after reset", 32'(sent_cnt - base_sent), 32'd0);
        check("no cmd_rdy after reset", 32'(cmdrdy_cnt - base_cr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
